// File: rtl/muldiv_unit_pkg.sv
// Shared types for the iterative multiply/divide unit: operation select and FSM state.
package muldiv_unit_pkg;

   typedef enum logic [2:0] {
      MUL    = 3'd0,
      MULH   = 3'd1,
      MULHSU = 3'd2,
      MULHU  = 3'd3,
      DIV    = 3'd4,
      DIVU   = 3'd5,
      REM    = 3'd6,
      REMU   = 3'd7
   } MULDIV_OP_t;

   typedef enum logic [2:0] {
      IDLE,
      PREP,
      CALC,
      FIX,
      DONE
   } MULDIV_STATE_t;

endpackage

// File: rtl/muldiv_unit_if.sv
// Request/response bundle of the multiply/divide unit; "unit" faces the datapath, "tb" the requester.
interface muldiv_unit_if #(parameter int unsigned XLEN = 32);
   import muldiv_unit_pkg::*;

   logic            flush;
   logic            in_valid;
   logic            in_ready;
   MULDIV_OP_t      op;
   logic [XLEN-1:0] in1;
   logic [XLEN-1:0] in2;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] out;
   logic            zero;
   logic            neg;
   logic            div_zero;

   modport unit (
      input  flush, in_valid, op, in1, in2, out_ready,
      output in_ready, out_valid, out, zero, neg, div_zero
   );

   modport tb (
      output flush, in_valid, op, in1, in2, out_ready,
      input  in_ready, out_valid, out, zero, neg, div_zero
   );

endinterface

// File: rtl/muldiv_unit_step.sv
// One bit of iteration on the {hi, lo} register pair: shift-add multiply (right shift)
// or restoring divide (left shift, quotient bit enters lo[0]).
module muldiv_unit_step #(
   parameter int unsigned XLEN = 32
) (
   input  logic            is_div_i,
   input  logic [XLEN-1:0] b_i,
   input  logic [XLEN-1:0] hi_i,
   input  logic [XLEN-1:0] lo_i,
   output logic [XLEN-1:0] hi_o,
   output logic [XLEN-1:0] lo_o
);

   logic [XLEN:0] sum;
   logic [XLEN:0] shl;
   logic [XLEN:0] diff;

   always_comb begin
      sum  = {1'b0, hi_i} + (lo_i[0] ? {1'b0, b_i} : '0);
      shl  = {hi_i, lo_i[XLEN-1]};
      diff = shl - {1'b0, b_i};
      if (is_div_i) begin
         // Partial remainder stays below the divisor, so bit XLEN of diff is the borrow.
         if (diff[XLEN]) begin
            hi_o = shl[XLEN-1:0];
            lo_o = {lo_i[XLEN-2:0], 1'b0};
         end else begin
            hi_o = diff[XLEN-1:0];
            lo_o = {lo_i[XLEN-2:0], 1'b1};
         end
      end else begin
         hi_o = sum[XLEN:1];
         lo_o = {sum[0], lo_i[XLEN-1:1]};
      end
   end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32 M-extension multiply/divide unit, STEP bits per CALC cycle.
// Define MULDIV_FAST_MUL_EN to compute MUL* ops with one combinational multiplier in PREP.
module muldiv_unit
   import muldiv_unit_pkg::*;
#(
   parameter int unsigned XLEN = 32,
   parameter int unsigned STEP = 1
) (
   input logic          CLK,
   input logic          nRST,
   muldiv_unit_if.unit  bus
);

   localparam int unsigned NCYC = XLEN / STEP;
   localparam int unsigned CW   = $clog2(NCYC);
   localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};

   MULDIV_STATE_t   state_q;
   MULDIV_OP_t      op_q;
   logic [XLEN-1:0] hi_q, lo_q, b_q;
   logic [CW-1:0]   cnt_q;
   logic            negq_q, negr_q, dz_q;
   logic [XLEN-1:0] out_q;
   logic            out_valid_q, zero_q, neg_q, div_zero_q;

   logic            is_div, a_sgn, b_sgn, div0, ovf;
   logic [XLEN-1:0] a_mag, b_mag;
   logic [2*XLEN-1:0] prod_d;
   logic [XLEN-1:0] res_d;
   logic [XLEN-1:0] step_hi, step_lo;

   // lo_q/b_q hold the raw operands during PREP, then magnitudes afterwards.
   always_comb begin
      is_div = op_q[2];
      a_sgn  = lo_q[XLEN-1] & (op_q inside {MUL, MULH, MULHSU, DIV, REM});
      b_sgn  = b_q[XLEN-1]  & (op_q inside {MUL, MULH, DIV, REM});
      a_mag  = a_sgn ? -lo_q : lo_q;
      b_mag  = b_sgn ? -b_q  : b_q;
      div0   = is_div && (b_q == '0);
      ovf    = (op_q inside {DIV, REM}) && (lo_q == XMIN) && (b_q == '1);
   end

   always_comb begin
      prod_d = {hi_q, lo_q};
      if (negq_q) prod_d = -prod_d;
      case (op_q)
         MULH, MULHSU, MULHU: res_d = prod_d[2*XLEN-1:XLEN];
         DIV, DIVU:           res_d = negq_q ? -lo_q : lo_q;
         REM, REMU:           res_d = negr_q ? -hi_q : hi_q;
         default:             res_d = prod_d[XLEN-1:0];
      endcase
   end

   for (genvar g = 0; g < STEP; g++) begin : g_stage
      logic [XLEN-1:0] hi_in, lo_in, hi_out, lo_out;
      if (g == 0) begin : g_first
         assign hi_in = hi_q;
         assign lo_in = lo_q;
      end else begin : g_next
         assign hi_in = g_stage[g-1].hi_out;
         assign lo_in = g_stage[g-1].lo_out;
      end
      muldiv_unit_step #(.XLEN(XLEN)) u_step (
         .is_div_i (is_div),
         .b_i      (b_q),
         .hi_i     (hi_in),
         .lo_i     (lo_in),
         .hi_o     (hi_out),
         .lo_o     (lo_out)
      );
   end
   assign step_hi = g_stage[STEP-1].hi_out;
   assign step_lo = g_stage[STEP-1].lo_out;

`ifdef MULDIV_FAST_MUL_EN
   logic [2*XLEN-1:0] fast_prod;
   assign fast_prod = (2*XLEN)'(a_mag) * (2*XLEN)'(b_mag);
`endif

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q     <= IDLE;
         op_q        <= MUL;
         hi_q        <= '0;
         lo_q        <= '0;
         b_q         <= '0;
         cnt_q       <= '0;
         negq_q      <= 1'b0;
         negr_q      <= 1'b0;
         dz_q        <= 1'b0;
         out_q       <= '0;
         out_valid_q <= 1'b0;
         zero_q      <= 1'b0;
         neg_q       <= 1'b0;
         div_zero_q  <= 1'b0;
      end else if (bus.flush) begin
         state_q     <= IDLE;
         out_valid_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (bus.in_valid) begin
               op_q    <= bus.op;
               lo_q    <= bus.in1;
               b_q     <= bus.in2;
               state_q <= PREP;
            end
            PREP: begin
               hi_q    <= '0;
               lo_q    <= a_mag;
               b_q     <= b_mag;
               cnt_q   <= CW'(NCYC - 1);
               negq_q  <= a_sgn ^ b_sgn;
               negr_q  <= a_sgn;
               dz_q    <= div0;
               state_q <= CALC;
               // Specials park the final quotient in lo and remainder in hi, unsigned.
               if (div0) begin
                  lo_q    <= '1;
                  hi_q    <= lo_q;
                  negq_q  <= 1'b0;
                  negr_q  <= 1'b0;
                  state_q <= FIX;
               end else if (ovf) begin
                  lo_q    <= XMIN;
                  hi_q    <= '0;
                  negq_q  <= 1'b0;
                  negr_q  <= 1'b0;
                  state_q <= FIX;
               end
`ifdef MULDIV_FAST_MUL_EN
               else if (!is_div) begin
                  {hi_q, lo_q} <= fast_prod;
                  state_q      <= FIX;
               end
`endif
            end
            CALC: begin
               hi_q  <= step_hi;
               lo_q  <= step_lo;
               cnt_q <= cnt_q - CW'(1);
               if (cnt_q == '0) state_q <= FIX;
            end
            FIX: begin
               out_q       <= res_d;
               zero_q      <= (res_d == '0);
               neg_q       <= res_d[XLEN-1];
               div_zero_q  <= dz_q;
               out_valid_q <= 1'b1;
               state_q     <= DONE;
            end
            DONE: if (bus.out_ready) begin
               out_valid_q <= 1'b0;
               state_q     <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = out_valid_q;
   assign bus.out       = out_q;
   assign bus.zero      = zero_q;
   assign bus.neg       = neg_q;
   assign bus.div_zero  = div_zero_q;

endmodule
